// File: rtl/program_loader_if.sv
// Byte-stream in, instruction-memory write port out.
// The host side drives the stream; the loader side drives the memory bus.
interface program_loader_if;
   logic        Start;
   logic [10:0] LoadWords;
   logic [7:0]  ByteIn;
   logic        ByteValid;
   logic        ByteReady;
   logic        MemWrite;
   logic [31:0] MemAddress;
   logic [31:0] MemWriteData;
   logic        Busy;
   logic        Done;
   logic        Error;

   modport slave (
      input  Start, LoadWords, ByteIn, ByteValid,
      output ByteReady, MemWrite, MemAddress, MemWriteData,
      output Busy, Done, Error
   );

   modport master (
      output Start, LoadWords, ByteIn, ByteValid,
      input  ByteReady, MemWrite, MemAddress, MemWriteData,
      input  Busy, Done, Error
   );
endinterface

// File: rtl/program_loader.sv
// Assembles little-endian words from a byte stream and writes them
// into instruction memory starting at the text-segment base.
module program_loader #(
   parameter int                MEMORY_DEPTH = 1024,
   parameter int                DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h00400000
) (
   input  logic clk,
   input  logic reset,
   program_loader_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [31:0] L_DEPTH = 32'(MEMORY_DEPTH);

   state_t                r_state, w_state;
   logic [10:0]           r_count, w_count;
   logic [10:0]           r_written, w_written;
   logic [1:0]            r_idx, w_idx;
   logic [DATA_WIDTH-1:0] r_addr, w_addr;
   logic [DATA_WIDTH-1:0] r_data, w_data;
   logic                  r_error, w_error;
   logic                  w_too_big;

   assign w_too_big = ({21'd0, bus.LoadWords} > L_DEPTH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_written <= '0;
         r_idx     <= '0;
         r_addr    <= TEXT_BASE;
         r_data    <= '0;
         r_error   <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_count   <= w_count;
         r_written <= w_written;
         r_idx     <= w_idx;
         r_addr    <= w_addr;
         r_data    <= w_data;
         r_error   <= w_error;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_count   = r_count;
      w_written = r_written;
      w_idx     = r_idx;
      w_addr    = r_addr;
      w_data    = r_data;
      w_error   = r_error;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.Start) begin
               if (w_too_big) begin
                  w_state = S_IDLE;
                  w_error = 1'b1;
               end else if (bus.LoadWords == 11'd0) begin
                  w_state = S_DONE;
                  w_error = 1'b0;
               end else begin
                  w_state   = S_COLLECT;
                  w_count   = bus.LoadWords;
                  w_written = '0;
                  w_idx     = '0;
                  w_addr    = TEXT_BASE;
                  w_error   = 1'b0;
               end
            end
         end
         S_COLLECT: begin
            if (bus.ByteValid) begin
               // first byte of a word lands in the LSB
               w_data[{r_idx, 3'b000} +: 8] = bus.ByteIn;
               w_idx = r_idx + 2'd1;
               if (r_idx == 2'd3) w_state = S_WRITE;
            end
         end
         S_WRITE: begin
            w_written = r_written + 11'd1;
            if (w_written == r_count) begin
               w_state = S_DONE;
            end else begin
               w_state = S_COLLECT;
               w_addr  = r_addr + DATA_WIDTH'(4);
               w_idx   = '0;
            end
         end
         default: w_state = S_IDLE;
      endcase
   end

   assign bus.ByteReady    = (r_state == S_COLLECT);
   assign bus.MemWrite     = (r_state == S_WRITE);
   assign bus.Busy         = (r_state == S_COLLECT) || (r_state == S_WRITE);
   assign bus.Done         = (r_state == S_DONE);
   assign bus.Error        = r_error;
   assign bus.MemAddress   = r_addr;
   assign bus.MemWriteData = r_data;

endmodule
